// File: rtl/iob_mem_writer_pkg.sv
// iob_mem_writer shared types: FSM state encoding.
// Consumed by iob_mem_writer and iob_mem_writer_csum.
package iob_mem_writer_pkg;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/iob_mem_writer_csum.sv
// iob_mem_writer_csum: DATA_W-wide XOR accumulator.
// clr has priority over en; both are synchronous.
module iob_mem_writer_csum
  import iob_mem_writer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q ^ d;
    end
  end
endmodule

// File: rtl/iob_mem_writer.sv
// iob_mem_writer: stream-to-RAM sequential loader with base/len.
// Define IOB_MEM_WRITER_VERIFY_EN to build the read-back checksum.
module iob_mem_writer
  import iob_mem_writer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_w_data,
  output logic              mem_r_en,
  input  logic [DATA_W-1:0] mem_r_data
);
  localparam logic [ADDR_W:0] REM_ONE = (ADDR_W + 1)'(1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   rem;
  logic              go, hs, last_hs;

  assign go      = (state == ST_IDLE) && start;
  assign hs      = (state == ST_WRITE) && s_valid;
  assign last_hs = hs && (rem == REM_ONE);

  assign s_ready    = (state == ST_WRITE);
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign mem_w_en   = hs;
  assign mem_w_data = hs ? s_data : '0;
  assign mem_addr   = addr;

`ifdef IOB_MEM_WRITER_VERIFY_EN
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [DATA_W-1:0] wsum, rsum;
  logic              r_en, r_pend, v_last, err_q;

  assign r_en     = (state == ST_VERIFY) && (rem != '0);
  assign v_last   = (state == ST_VERIFY) && (rem == '0) && r_pend;
  assign mem_r_en = r_en;
  assign error    = err_q;

  iob_mem_writer_csum #(.DATA_W(DATA_W)) u_wsum (
    .clk(clk), .rst_n(rst_n), .clr(go),
    .en(hs), .d(s_data), .q(wsum)
  );

  iob_mem_writer_csum #(.DATA_W(DATA_W)) u_rsum (
    .clk(clk), .rst_n(rst_n), .clr(go),
    .en(r_pend), .d(mem_r_data), .q(rsum)
  );

  // The final return is folded in directly, not via rsum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      len_q  <= '0;
      r_pend <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      r_pend <= r_en;
      if (go) begin
        base_q <= base_addr;
        len_q  <= len;
        err_q  <= 1'b0;
      end else if (v_last) begin
        err_q <= ((rsum ^ mem_r_data) != wsum);
      end
    end
  end
`else
  logic unused_r_data;
  assign unused_r_data = ^mem_r_data;
  assign mem_r_en      = 1'b0;
  assign error         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      rem  <= '0;
    end else if (go) begin
      addr <= base_addr;
      rem  <= len;
`ifdef IOB_MEM_WRITER_VERIFY_EN
    end else if (last_hs) begin
      addr <= base_q;
      rem  <= len_q;
    end else if (r_en) begin
      addr <= addr + 1'b1;
      rem  <= rem - 1'b1;
`endif
    end else if (hs) begin
      addr <= addr + 1'b1;
      rem  <= rem - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (1'b1)
      (state == ST_IDLE): begin
        if (start) state_n = (len == '0) ? ST_DONE : ST_WRITE;
      end
      (state == ST_WRITE): begin
`ifdef IOB_MEM_WRITER_VERIFY_EN
        if (last_hs) state_n = ST_VERIFY;
`else
        if (last_hs) state_n = ST_DONE;
`endif
      end
      (state == ST_VERIFY): begin
`ifdef IOB_MEM_WRITER_VERIFY_EN
        if (v_last) state_n = ST_DONE;
`else
        state_n = ST_IDLE;
`endif
      end
      (state == ST_DONE): state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end
endmodule
